fsmc_reg_arbiter: RTL and testbench

- Owns the shared register bank behind the clocked FSMC bus slave.
- Arbitrates the bank's single access port between the external bus (do_read/do_write strobes) and two internal requesters using a req/gnt handshake.
- Bus accesses always win, because the slave samples read data at a fixed point. Internal requesters share the remaining cycles round-robin.
- The top bank address is a read-only STATUS register that is cleared on read; this is the read side-effect the bus slave's do_read strobe exists for.

---
 rtl/fsmc_reg_arbiter.sv | 108 ++++++++++
 tb/tb_fsmc_reg_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsmc_reg_arbiter.sv
// Shared register bank behind the FSMC bus slave: the bus always owns the port
// when it strobes, two internal requesters share the other cycles round-robin.
module fsmc_reg_arbiter #(
  parameter int ADRW = 2,
  parameter int DATW = 8
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [ADRW-1:0]               bus_adr,
  input  logic                          bus_do_read,
  input  logic                          bus_do_write,
  input  logic [DATW-1:0]               bus_w_data,
  output logic [DATW-1:0]               bus_r_data,
  input  logic [1:0]                    req,
  input  logic [1:0]                    we,
  input  logic [2*ADRW-1:0]             int_adr,
  input  logic [2*DATW-1:0]             int_w_data,
  output logic [1:0]                    gnt,
  output logic [DATW-1:0]               int_r_data,
  output logic                          int_r_valid,
  output logic [(2**ADRW-1)*DATW-1:0]   led_regs
);

  localparam int NREG = 2**ADRW;
  localparam logic [ADRW-1:0] STAT_ADR = ADRW'(NREG-1);

  logic [DATW-1:0] regs [NREG-1];
  logic [3:0]      status;
  logic            rr_ptr;
  logic            bus_act;
  logic            int_sel;
  logic            int_we_sel;
  logic [ADRW-1:0] int_adr_sel;
  logic [DATW-1:0] int_wd_sel;
  logic [DATW-1:0] int_img;
  logic [DATW-1:0] rd_data_p1;
  logic            vld_p1;

  assign bus_act     = bus_do_read | bus_do_write;
  assign int_sel     = gnt[1];
  assign int_we_sel  = we[int_sel];
  assign int_adr_sel = int_sel ? int_adr[2*ADRW-1:ADRW] : int_adr[ADRW-1:0];
  assign int_wd_sel  = int_sel ? int_w_data[2*DATW-1:DATW] : int_w_data[DATW-1:0];

  // Bus strobes block internal grants outright; otherwise rr_ptr is preferred.
  always_comb begin
    gnt = '0;
    if (!bus_act) begin
      if (req[rr_ptr])       gnt[rr_ptr]  = 1'b1;
      else if (req[~rr_ptr]) gnt[~rr_ptr] = 1'b1;
    end
  end

  always_comb begin
    bus_r_data = '0;
    if (bus_adr == STAT_ADR) bus_r_data[3:0] = status;
    else                     bus_r_data      = regs[bus_adr];
  end

  always_comb begin
    int_img = '0;
    if (int_adr_sel == STAT_ADR) int_img[3:0] = status;
    else                         int_img      = regs[int_adr_sel];
  end

  for (genvar i = 0; i < NREG-1; i++) begin : g_led
    assign led_regs[i*DATW +: DATW] = regs[i];
  end

  // Stage p0 -> p1: bank update and registered internal read data
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NREG-1; i++) regs[i] <= '0;
      status     <= '0;
      rr_ptr     <= 1'b0;
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (bus_do_write) begin
        if (bus_adr != STAT_ADR) regs[bus_adr] <= bus_w_data;
      end else if (bus_do_read) begin
        if (bus_adr == STAT_ADR) status <= '0;
      end else if (|gnt) begin
        rr_ptr <= ~int_sel;
        if (int_we_sel) begin
          if (int_adr_sel == STAT_ADR) begin
            status[{1'b1, int_sel}] <= 1'b1;
          end else begin
            regs[int_adr_sel]       <= int_wd_sel;
            status[{1'b0, int_sel}] <= 1'b1;
          end
        end else begin
          rd_data_p1 <= int_img;
          vld_p1     <= 1'b1;
        end
      end
    end
  end

  assign int_r_data  = rd_data_p1;
  assign int_r_valid = vld_p1;

  // A simultaneous read/write strobe drops the read; the slave should never do it.
  a_strobe_excl: assert property (@(posedge clk) disable iff (!nrst)
    !(bus_do_read && bus_do_write));

endmodule

// File: tb/tb_fsmc_reg_arbiter.sv
// Scenario bench for fsmc_reg_arbiter with a queue scoreboard for internal reads.
module tb_fsmc_reg_arbiter;
  localparam int ADRW = 2;
  localparam int DATW = 8;
  localparam int NREG = 4;

  logic             clk = 1'b0;
  logic             nrst;
  logic [ADRW-1:0]  bus_adr;
  logic             bus_do_read;
  logic             bus_do_write;
  logic [DATW-1:0]  bus_w_data;
  logic [DATW-1:0]  bus_r_data;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [2*ADRW-1:0] int_adr;
  logic [2*DATW-1:0] int_w_data;
  logic [1:0]       gnt;
  logic [DATW-1:0]  int_r_data;
  logic             int_r_valid;
  logic [(NREG-1)*DATW-1:0] led_regs;

  fsmc_reg_arbiter #(.ADRW(ADRW), .DATW(DATW)) dut (
    .clk(clk), .nrst(nrst), .bus_adr(bus_adr), .bus_do_read(bus_do_read),
    .bus_do_write(bus_do_write), .bus_w_data(bus_w_data), .bus_r_data(bus_r_data),
    .req(req), .we(we), .int_adr(int_adr), .int_w_data(int_w_data), .gnt(gnt),
    .int_r_data(int_r_data), .int_r_valid(int_r_valid), .led_regs(led_regs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DATW-1:0] exp_q[$];
  logic [DATW-1:0] mregs [NREG];
  logic [3:0]      mstat;
  logic            mptr;

  function automatic logic [DATW-1:0] mread(input logic [ADRW-1:0] a);
    if (a == 2'd3) return {4'h0, mstat};
    return mregs[a];
  endfunction

  function automatic logic [(NREG-1)*DATW-1:0] mled();
    return {mregs[2], mregs[1], mregs[0]};
  endfunction

  function automatic logic [1:0] mgnt(input logic [1:0] r);
    if (r[mptr])  return mptr ? 2'b10 : 2'b01;
    if (r[~mptr]) return mptr ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  // Scoreboard: every int_r_valid pulse pops the oldest expected read value.
  always @(negedge clk) begin : sb
    logic [DATW-1:0] e;
    if (nrst && int_r_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL int_r_unexpected: got valid data %h, required no valid", int_r_data);
      end else begin
        e = exp_q.pop_front();
        if (int_r_data !== e) begin
          errors++;
          $display("FAIL int_r_data: got %h, required %h", int_r_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    mstat = '0;
    mptr  = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; bus_adr = 2'd3; bus_do_read = 0; bus_do_write = 0; bus_w_data = '0;
    req = '0; we = '0; int_adr = '0; int_w_data = '0;
    model_reset();
    tick(); tick();
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00 || int_r_valid !== 1'b0 || int_r_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt %b vld %b data %h, required 00 0 00", gnt, int_r_valid, int_r_data);
    end
    checks++;
    if (led_regs !== '0 || bus_r_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs: got led %h status %h, required 0 0", led_regs, bus_r_data);
    end
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_bus_rw();
    bus_adr = 2'd1; bus_w_data = 8'hA5; bus_do_write = 1;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL bus_wr_gnt: got %b, required 00", gnt); end
    mregs[1] = 8'hA5;
    tick();
    bus_do_write = 0; bus_do_read = 1;
    @(negedge clk);
    checks++;
    if (bus_r_data !== 8'hA5 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL bus_rd: got data %h gnt %b, required a5 00", bus_r_data, gnt);
    end
    tick();
    bus_do_read = 0;
    checks++;
    if (led_regs !== mled()) begin errors++; $display("FAIL bus_led: got %h, required %h", led_regs, mled()); end
  endtask

  task automatic test_int_write();
    req = 2'b01; we = 2'b01; int_adr = {2'd0, 2'd2}; int_w_data = {8'h00, 8'h3C};
    @(negedge clk);
    checks++;
    if (gnt !== mgnt(req)) begin errors++; $display("FAIL int_wr_gnt: got %b, required %b", gnt, mgnt(req)); end
    mregs[2] = 8'h3C; mstat[0] = 1'b1; mptr = 1'b1;
    tick();
    req = '0;
    checks++;
    if (led_regs !== mled()) begin errors++; $display("FAIL int_wr_led: got %h, required %h", led_regs, mled()); end
    bus_adr = 2'd3; bus_do_read = 1;
    @(negedge clk);
    checks++;
    if (bus_r_data !== 8'h01) begin errors++; $display("FAIL status_rd1: got %h, required 01", bus_r_data); end
    mstat = '0;
    tick();
    @(negedge clk);
    checks++;
    if (bus_r_data !== 8'h00) begin errors++; $display("FAIL status_rd2: got %h, required 00", bus_r_data); end
    tick();
    bus_do_read = 0;
  endtask

  task automatic test_rr_reads();
    logic [1:0] eg;
    req = 2'b11; we = 2'b00; int_adr = {2'd2, 2'd1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      eg = mgnt(req);
      checks++;
      if (gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d]: got %b, required %b", i, gnt, eg); end
      exp_q.push_back(mread(eg[1] ? int_adr[3:2] : int_adr[1:0]));
      mptr = ~eg[1];
      tick();
    end
    req = '0;
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rr_pending: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_bus_priority();
    req = 2'b01; we = 2'b01; int_adr = {2'd0, 2'd0}; int_w_data = {8'h00, 8'h11};
    bus_adr = 2'd1; bus_w_data = 8'h5A; bus_do_write = 1;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL prio_bus_gnt: got %b, required 00", gnt); end
    mregs[1] = 8'h5A;
    tick();
    bus_do_write = 0;
    @(negedge clk);
    checks++;
    if (gnt !== mgnt(req)) begin errors++; $display("FAIL prio_int_gnt: got %b, required %b", gnt, mgnt(req)); end
    mregs[0] = 8'h11; mstat[0] = 1'b1; mptr = 1'b1;
    tick();
    req = '0;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00 || led_regs !== mled()) begin
      errors++;
      $display("FAIL prio_after: got gnt %b led %h, required 00 %h", gnt, led_regs, mled());
    end
    tick();
  endtask

  task automatic test_status_write();
    bus_adr = 2'd3; bus_do_read = 1;
    @(negedge clk);
    checks++;
    if (bus_r_data !== mread(2'd3)) begin errors++; $display("FAIL sw_clear: got %h, required %h", bus_r_data, mread(2'd3)); end
    mstat = '0;
    tick();
    bus_do_read = 0;
    req = 2'b10; we = 2'b10; int_adr = {2'd3, 2'd0}; int_w_data = {8'h77, 8'h00};
    @(negedge clk);
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL sw_gnt: got %b, required 10", gnt); end
    mstat[3] = 1'b1; mptr = 1'b0;
    tick();
    req = '0;
    bus_w_data = 8'hFF; bus_do_write = 1;
    tick();
    bus_do_write = 0;
    @(negedge clk);
    checks++;
    if (bus_r_data !== 8'h08 || led_regs !== mled()) begin
      errors++;
      $display("FAIL sw_status: got %h led %h, required 08 %h", bus_r_data, led_regs, mled());
    end
    tick();
  endtask

  task automatic test_reset_midop();
    req = 2'b10; we = 2'b00; int_adr = {2'd2, 2'd0};
    @(negedge clk);
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL mid_gnt: got %b, required 10", gnt); end
    nrst = 1'b0;
    req = '0;
    model_reset();
    tick();
    checks++;
    if (int_r_valid !== 1'b0 || led_regs !== '0) begin
      errors++;
      $display("FAIL mid_reset: got vld %b led %h, required 0 0", int_r_valid, led_regs);
    end
    tick();
    nrst = 1'b1;
    tick();
    checks++;
    if (int_r_valid !== 1'b0) begin errors++; $display("FAIL mid_vld: got %b, required 0", int_r_valid); end
    req = 2'b11; we = 2'b00; int_adr = {2'd1, 2'd0};
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL mid_rr: got %b, required 01", gnt); end
    exp_q.push_back(mread(2'd0));
    mptr = 1'b1;
    tick();
    req = '0;
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mid_pending: got %0d left, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_bus_rw();
    test_int_write();
    test_rr_reads();
    test_bus_priority();
    test_status_write();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish before 100000");
    $fatal(1);
  end

endmodule
